// File: rtl/pf_ddr4_iod_rx_align.sv
// RX word aligner for a PolarFire DDR4 IOD lane in 4:1 mode: slips the IOD until PATTERN locks.
// Optional macro RX_ALIGN_OUT_PIPE_EN adds one output register stage on DATA_OUT/DATA_VALID.
module pf_ddr4_iod_rx_align #(
  parameter logic [3:0] PATTERN       = 4'hC,
  parameter int         MATCH_CNT     = 8,
  parameter int         WINDOW        = 16,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         MAX_SLIPS     = 3
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic [3:0] RX_DATA,
  input  logic       TRAIN_START,
  output logic       RX_BIT_SLIP,
  output logic       ALIGN_DONE,
  output logic       ALIGN_FAIL,
  output logic [2:0] SLIP_COUNT,
  output logic [3:0] DATA_OUT,
  output logic       DATA_VALID
);
  localparam logic [7:0] MATCH_LIM  = 8'(MATCH_CNT);
  localparam logic [7:0] WIN_LIM    = 8'(WINDOW);
  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);
  localparam logic [2:0] SLIP_LIM   = 3'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_SLIP, S_SETTLE, S_LOCKED, S_FAIL
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] rx_q;
  logic [7:0] match_q, match_d, win_q, win_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] slip_cnt_q, slip_cnt_d;
  logic       slip_q, done_q, fail_q;
  logic [3:0] dout_q;
  logic       dv_q;
  logic       hit;
  logic [7:0] match_inc, win_inc;
  logic [3:0] settle_inc;

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    win_d      = win_q;
    settle_d   = settle_q;
    slip_cnt_d = slip_cnt_q;
    hit        = (rx_q == PATTERN);
    match_inc  = match_q + 8'd1;
    win_inc    = win_q + 8'd1;
    settle_inc = settle_q + 4'd1;
    case (state_q)
      S_IDLE: ;
      S_COMPARE: begin
        win_d   = win_inc;
        match_d = hit ? match_inc : 8'd0;
        // lock wins over window expiry on the same cycle
        if (hit && match_inc == MATCH_LIM)
          state_d = S_LOCKED;
        else if (win_inc == WIN_LIM)
          state_d = (slip_cnt_q < SLIP_LIM) ? S_SLIP : S_FAIL;
      end
      S_SLIP: begin
        state_d    = S_SETTLE;
        settle_d   = 4'd0;
        slip_cnt_d = TRAIN_START ? 3'd0 : slip_cnt_q + 3'd1;
      end
      S_SETTLE: begin
        settle_d = settle_inc;
        if (settle_inc == SETTLE_LIM) begin
          state_d = S_COMPARE;
          match_d = 8'd0;
          win_d   = 8'd0;
        end
      end
      S_LOCKED, S_FAIL: ;
      default: state_d = S_IDLE;
    endcase
    // a restart in SLIP is handled above so the IOD still gets its settle time
    if (TRAIN_START && state_q != S_SLIP) begin
      state_d    = S_COMPARE;
      match_d    = 8'd0;
      win_d      = 8'd0;
      settle_d   = 4'd0;
      slip_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q    <= S_IDLE;
      rx_q       <= 4'd0;
      match_q    <= 8'd0;
      win_q      <= 8'd0;
      settle_q   <= 4'd0;
      slip_cnt_q <= 3'd0;
      slip_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      dout_q     <= 4'd0;
      dv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_q       <= RX_DATA;
      match_q    <= match_d;
      win_q      <= win_d;
      settle_q   <= settle_d;
      slip_cnt_q <= slip_cnt_d;
      slip_q     <= (state_d == S_SLIP);
      done_q     <= (state_d == S_LOCKED);
      fail_q     <= (state_d == S_FAIL);
      // loads the same word rx_q takes, so DATA_OUT tracks rx_q while locked
      dout_q     <= (state_d == S_LOCKED) ? RX_DATA : 4'd0;
      dv_q       <= (state_d == S_LOCKED);
    end
  end

`ifdef RX_ALIGN_OUT_PIPE_EN
  logic [3:0] dout_p_q;
  logic       dv_p_q;

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      dout_p_q <= 4'd0;
      dv_p_q   <= 1'b0;
    end else begin
      dout_p_q <= dout_q;
      dv_p_q   <= dv_q;
    end
  end

  assign DATA_OUT   = dout_p_q;
  assign DATA_VALID = dv_p_q;
`else
  assign DATA_OUT   = dout_q;
  assign DATA_VALID = dv_q;
`endif

  assign RX_BIT_SLIP = slip_q;
  assign ALIGN_DONE  = done_q;
  assign ALIGN_FAIL  = fail_q;
  assign SLIP_COUNT  = slip_cnt_q;
endmodule

// File: tb/tb_pf_ddr4_iod_rx_align.sv
// Randomized bench for pf_ddr4_iod_rx_align: a rotating-word IOD plant plus an edge-timeline model.
module tb_pf_ddr4_iod_rx_align;
  localparam logic [3:0] PAT = 4'hC;
  localparam int MATCH = 8, WIN = 16, SETTLE = 4, MAXS = 3;
  localparam int POS_COST = WIN + 1 + SETTLE;
  localparam int FAIL_E   = MAXS * POS_COST + WIN;

  logic       FAB_CLK = 1'b0;
  logic       ARST = 1'b1;
  logic [3:0] RX_DATA = 4'd0;
  logic       TRAIN_START = 1'b0;
  logic       RX_BIT_SLIP, ALIGN_DONE, ALIGN_FAIL, DATA_VALID;
  logic [2:0] SLIP_COUNT;
  logic [3:0] DATA_OUT;
  int checks = 0;
  int fails = 0;

  pf_ddr4_iod_rx_align dut (
    .FAB_CLK(FAB_CLK), .ARST(ARST), .RX_DATA(RX_DATA), .TRAIN_START(TRAIN_START),
    .RX_BIT_SLIP(RX_BIT_SLIP), .ALIGN_DONE(ALIGN_DONE), .ALIGN_FAIL(ALIGN_FAIL),
    .SLIP_COUNT(SLIP_COUNT), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
    logic [3:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  // Trains from edge 0 with the IOD word starting at init; g>0 corrupts the g-th compared word.
  task automatic run_scenario(input logic [3:0] init, input int g, input string nm);
    logic [3:0] samp [0:127];
    logic [3:0] cur;
    int lock_e, nsl, end_e, k;
    logic e_slip, e_done, e_fail, e_dv;
    logic [3:0] e_do;
    logic [2:0] e_cnt;
    lock_e = -1;
    nsl = MAXS;
    for (int n = 0; n <= MAXS; n++)
      if (lock_e < 0 && rotl(init, n) == PAT) begin
        lock_e = n * POS_COST + MATCH + ((n == 0) ? g : 0);
        nsl = n;
      end
    end_e = (lock_e >= 0) ? lock_e + 12 : FAIL_E + 6;
    cur = init;
    TRAIN_START = 1'b1;
    RX_DATA = (g == 1) ? 4'h0 : cur;
    for (int e = 0; e <= end_e; e++) begin
      samp[e] = RX_DATA;
      @(posedge FAB_CLK); #1;
      k = 0;
      e_slip = 1'b0;
      for (int n = 0; n < nsl; n++) begin
        if (e >= n * POS_COST + WIN + 1) k++;
        if (e == n * POS_COST + WIN) e_slip = 1'b1;
      end
      e_cnt  = 3'(k);
      e_done = (lock_e >= 0 && e >= lock_e);
      e_fail = (lock_e < 0 && e >= FAIL_E);
`ifdef RX_ALIGN_OUT_PIPE_EN
      e_dv = (lock_e >= 0 && e >= lock_e + 1);
      e_do = e_dv ? samp[e-1] : 4'd0;
`else
      e_dv = e_done;
      e_do = e_dv ? samp[e] : 4'd0;
`endif
      checks += 6;
      if (RX_BIT_SLIP !== e_slip) begin fails++; $display("FAIL %s slip e%0d got %b exp %b", nm, e, RX_BIT_SLIP, e_slip); end
      if (SLIP_COUNT !== e_cnt) begin fails++; $display("FAIL %s slip_count e%0d got %0d exp %0d", nm, e, SLIP_COUNT, e_cnt); end
      if (ALIGN_DONE !== e_done) begin fails++; $display("FAIL %s done e%0d got %b exp %b", nm, e, ALIGN_DONE, e_done); end
      if (ALIGN_FAIL !== e_fail) begin fails++; $display("FAIL %s align_fail e%0d got %b exp %b", nm, e, ALIGN_FAIL, e_fail); end
      if (DATA_VALID !== e_dv) begin fails++; $display("FAIL %s valid e%0d got %b exp %b", nm, e, DATA_VALID, e_dv); end
      if (DATA_OUT !== e_do) begin fails++; $display("FAIL %s data e%0d got %h exp %h", nm, e, DATA_OUT, e_do); end
      TRAIN_START = 1'b0;
      if (RX_BIT_SLIP) cur = rotl(cur, 1);
      if (lock_e >= 0 && e + 1 > lock_e) RX_DATA = 4'($urandom_range(0, 15));
      else if (g > 0 && e + 1 == g - 1) RX_DATA = 4'h0;
      else RX_DATA = cur;
    end
  endtask

  task automatic test_reset();
    ARST = 1'b1;
    repeat (3) @(posedge FAB_CLK);
    #1;
    checks++;
    if ({RX_BIT_SLIP, ALIGN_DONE, ALIGN_FAIL, SLIP_COUNT, DATA_OUT, DATA_VALID} !== 11'd0) begin
      fails++;
      $display("FAIL reset outputs got %b exp 0", {RX_BIT_SLIP, ALIGN_DONE, ALIGN_FAIL, SLIP_COUNT, DATA_OUT, DATA_VALID});
    end
    ARST = 1'b0;
  endtask

  task automatic test_idle();
    RX_DATA = PAT;
    repeat (20) begin
      @(posedge FAB_CLK); #1;
      checks++;
      if (ALIGN_DONE !== 1'b0 || RX_BIT_SLIP !== 1'b0 || DATA_VALID !== 1'b0) begin
        fails++;
        $display("FAIL idle got done=%b slip=%b valid=%b exp 0", ALIGN_DONE, RX_BIT_SLIP, DATA_VALID);
      end
    end
  endtask

  task automatic test_aligned();   run_scenario(4'hC, 0, "aligned");  endtask
  task automatic test_two_slip();  run_scenario(4'h3, 0, "two_slip"); endtask

  task automatic test_random_align();
    logic [3:0] starts [4];
    starts = '{4'hC, 4'h6, 4'h3, 4'h9};
    repeat (4) run_scenario(starts[$urandom_range(0, 3)], 0, "rand_align");
  endtask

  task automatic test_fail();
    logic [3:0] bad [12];
    bad = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'hA, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF};
    run_scenario(4'h5, 0, "fail");
    run_scenario(4'hC, 0, "restart_from_fail");
    run_scenario(bad[$urandom_range(0, 11)], 0, "rand_fail");
  endtask

  task automatic test_glitch();
    run_scenario(4'hC, 8, "glitch_7_1");
    repeat (3) run_scenario(4'hC, $urandom_range(1, 8), "rand_glitch");
  endtask

  task automatic test_slip_restart();
    logic [3:0] cur;
    cur = 4'h3;
    TRAIN_START = 1'b1;
    RX_DATA = cur;
    for (int e = 0; e <= 55; e++) begin
      @(posedge FAB_CLK); #1;
      TRAIN_START = (e == 16);
      if (e == 16 || e == 37) begin
        checks++;
        if (RX_BIT_SLIP !== 1'b1) begin fails++; $display("FAIL slip_restart pulse e%0d got %b exp 1", e, RX_BIT_SLIP); end
      end else if (e == 17 || e == 18) begin
        checks += 2;
        if (RX_BIT_SLIP !== 1'b0) begin fails++; $display("FAIL slip_restart width e%0d got %b exp 0", e, RX_BIT_SLIP); end
        if (SLIP_COUNT !== 3'd0) begin fails++; $display("FAIL slip_restart count e%0d got %0d exp 0", e, SLIP_COUNT); end
      end else if (e == 49 || e == 50) begin
        checks += 2;
        if (ALIGN_DONE !== (e == 50)) begin fails++; $display("FAIL slip_restart done e%0d got %b exp %b", e, ALIGN_DONE, e == 50); end
        if (SLIP_COUNT !== 3'd1) begin fails++; $display("FAIL slip_restart final_count e%0d got %0d exp 1", e, SLIP_COUNT); end
      end
      if (RX_BIT_SLIP) cur = rotl(cur, 1);
      RX_DATA = cur;
    end
    TRAIN_START = 1'b0;
  endtask

  task automatic test_arst_settle();
    int seen;
    TRAIN_START = 1'b1;
    RX_DATA = 4'h6;
    for (int e = 0; e <= 19; e++) begin
      @(posedge FAB_CLK); #1;
      TRAIN_START = 1'b0;
    end
    checks++;
    if (SLIP_COUNT !== 3'd1) begin fails++; $display("FAIL arst pre_count got %0d exp 1", SLIP_COUNT); end
    #2 ARST = 1'b1;
    #1;
    checks++;
    if ({RX_BIT_SLIP, ALIGN_DONE, ALIGN_FAIL, SLIP_COUNT, DATA_OUT, DATA_VALID} !== 11'd0) begin
      fails++;
      $display("FAIL arst async got %b exp 0", {RX_BIT_SLIP, ALIGN_DONE, ALIGN_FAIL, SLIP_COUNT, DATA_OUT, DATA_VALID});
    end
    repeat (2) @(posedge FAB_CLK);
    #1 ARST = 1'b0;
    RX_DATA = PAT;
    seen = 0;
    repeat (30) begin
      @(posedge FAB_CLK); #1;
      if (RX_BIT_SLIP || ALIGN_DONE) seen++;
    end
    checks++;
    if (seen != 0) begin fails++; $display("FAIL arst post_idle activity got %0d exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_aligned();
    test_two_slip();
    test_random_align();
    test_fail();
    test_glitch();
    test_aligned();
    test_slip_restart();
    test_arst_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
